demux_scan_ctrl: RTL and testbench

DEMUX_SCAN_CTRL -- requirements
Module: demux_scan_ctrl

---
 rtl/demux_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_demux_scan_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_scan_ctrl.sv
// Serialises an 8-bit word onto a 1x8 demux: channel n is selected for DWELL
// cycles while bit n is driven on i; a one-cycle done pulse follows channel 7.
module demux_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic [2:0] s,
    output logic       i,
    output logic       scan_active,
    output logic       done
);

    localparam int unsigned CH_W    = 3;
    localparam int unsigned DWELL_W = 4;
    localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DWELL - 1);
    localparam logic [CH_W-1:0]    LAST_CH      = CH_W'(7);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         held_q, held_d;
    logic [2:0]         s_q, s_d;
    logic               i_q, i_d;
    logic               scan_active_q, scan_active_d;
    logic               done_q, done_d;

    // Abort takes priority over a pending word in IDLE.
    assign in_ready = (state_q == IDLE) && !abort;

    assign s           = s_q;
    assign i           = i_q;
    assign scan_active = scan_active_q;
    assign done        = done_q;

    // Next state and registered outputs; outputs default to the quiet value.
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        dwell_d       = dwell_q;
        held_d        = held_q;
        s_d           = '0;
        i_d           = 1'b0;
        scan_active_d = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d       = SCAN;
                    held_d        = in_data;
                    ch_d          = '0;
                    dwell_d       = DWELL_RELOAD;
                    s_d           = '0;
                    i_d           = in_data[0];
                    scan_active_d = 1'b1;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                    ch_d    = '0;
                    dwell_d = '0;
                end else if (dwell_q == '0) begin
                    if (ch_q == LAST_CH) begin
                        state_d = DONE;
                        ch_d    = '0;
                        done_d  = 1'b1;
                    end else begin
                        ch_d          = ch_q + CH_W'(1);
                        dwell_d       = DWELL_RELOAD;
                        s_d           = ch_d;
                        i_d           = held_q[ch_d];
                        scan_active_d = 1'b1;
                    end
                end else begin
                    dwell_d       = dwell_q - DWELL_W'(1);
                    s_d           = ch_q;
                    i_d           = held_q[ch_q];
                    scan_active_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ch_d    = '0;
                dwell_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            dwell_q       <= '0;
            held_q        <= '0;
            s_q           <= '0;
            i_q           <= 1'b0;
            scan_active_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            dwell_q       <= dwell_d;
            held_q        <= held_d;
            s_q           <= s_d;
            i_q           <= i_d;
            scan_active_q <= scan_active_d;
            done_q        <= done_d;
        end
    end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Scoreboard bench for demux_scan_ctrl: instance a uses DWELL=2, instance b DWELL=1.
module tb_demux_scan_ctrl;

    typedef struct packed {
        logic [2:0] s;
        logic       i;
        logic       sa;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       abort;
    logic       use_b;
    logic [7:0] in_data;

    logic       in_ready_a, i_a, sa_a, done_a;
    logic [2:0] s_a;
    logic       in_ready_b, i_b, sa_b, done_b;
    logic [2:0] s_b;

    exp_t       obs;
    logic       in_ready_o;
    exp_t       q[$];
    int         checks;
    int         errors;

    always #5 clk = ~clk;

    demux_scan_ctrl #(.DWELL(2)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid && !use_b),
        .in_ready    (in_ready_a),
        .abort       (abort && !use_b),
        .s           (s_a),
        .i           (i_a),
        .scan_active (sa_a),
        .done        (done_a)
    );

    demux_scan_ctrl #(.DWELL(1)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid && use_b),
        .in_ready    (in_ready_b),
        .abort       (abort && use_b),
        .s           (s_b),
        .i           (i_b),
        .scan_active (sa_b),
        .done        (done_b)
    );

    assign obs        = use_b ? {s_b, i_b, sa_b, done_b} : {s_a, i_a, sa_a, done_a};
    assign in_ready_o = use_b ? in_ready_b : in_ready_a;

    // Expected per-cycle outputs for a full scan of word w followed by the done cycle.
    function automatic void push_scan(input logic [7:0] w, input int dwell);
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < dwell; r++) begin
                q.push_back('{s: 3'(k), i: w[k], sa: 1'b1, done: 1'b0});
            end
        end
        q.push_back('{s: 3'd0, i: 1'b0, sa: 1'b0, done: 1'b1});
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; in_data = 8'hFF; use_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_a, i_a, sa_a, done_a, s_b, i_b, sa_b, done_b} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got a=%h b=%h exp 00", obs, {s_b, i_b, sa_b, done_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got a=%b b=%b exp 1", in_ready_a, in_ready_b);
        end
    endtask

    task automatic test_dwell2();
        exp_t e;
        int   cyc;
        use_b = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++; $display("FAIL dwell2_ready got %b exp 1", in_ready_o);
        end
        in_valid = 1'b1; in_data = 8'hA5;
        push_scan(8'hA5, 2);
        cyc = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            in_valid = 1'b0; in_data = 8'h00;
            cyc++;
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL dwell2_scan cyc %0d got %h exp %h", cyc, obs, e);
            end
        end
        @(negedge clk);
        checks++;
        if (obs !== 6'h00 || in_ready_o !== 1'b1) begin
            errors++; $display("FAIL dwell2_idle cyc 18 got out=%h rdy=%b exp out=00 rdy=1", obs, in_ready_o);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [7:0]  words [2];
        words[0] = 8'hFF; words[1] = 8'h00;
        use_b = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (in_ready_o !== 1'b1 || obs !== 6'h00) begin
                errors++; $display("FAIL b2b_ready word %0d got rdy=%b out=%h exp rdy=1 out=00", w, in_ready_o, obs);
            end
            in_valid = 1'b1; in_data = words[w];
            push_scan(words[w], 1);
            while (q.size() > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                e = q.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++; $display("FAIL b2b_scan word %0d got %h exp %h", w, obs, e);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (in_ready_o !== 1'b1 || obs !== 6'h00) begin
            errors++; $display("FAIL b2b_final got rdy=%b out=%h exp rdy=1 out=00", in_ready_o, obs);
        end
        use_b = 1'b0;
    endtask

    task automatic test_abort();
        exp_t e;
        use_b = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h3C;
        push_scan(8'h3C, 2);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL abort_scan cyc %0d got %h exp %h", c, obs, e);
            end
        end
        q.delete();
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 6'h00) begin
            errors++; $display("FAIL abort_outputs got %h exp 00", obs);
        end
        abort = 1'b0;
        #1;
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++; $display("FAIL abort_ready got %b exp 1", in_ready_o);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs !== 6'h00) begin
                errors++; $display("FAIL abort_no_done got %h exp 00", obs);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        exp_t e;
        use_b = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h5A;
        push_scan(8'h5A, 2);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL rstmid_scan cyc %0d got %h exp %h", c, obs, e);
            end
        end
        checks++;
        if (obs.s !== 3'd4) begin
            errors++; $display("FAIL rstmid_s4 got %0d exp 4", obs.s);
        end
        q.delete();
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 6'h00) begin
            errors++; $display("FAIL rstmid_async got %h exp 00", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (obs !== 6'h00 || in_ready_o !== 1'b1) begin
                errors++; $display("FAIL rstmid_idle got out=%h rdy=%b exp out=00 rdy=1", obs, in_ready_o);
            end
        end
    endtask

    task automatic test_hold_word();
        exp_t e;
        use_b = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h96;
        push_scan(8'h96, 2);
        while (q.size() > 0) begin
            @(negedge clk);
            in_data = 8'($urandom);
            e = q.pop_front();
            checks++;
            if (obs !== e || in_ready_o !== 1'b0) begin
                errors++; $display("FAIL hold_scan got out=%h rdy=%b exp out=%h rdy=0", obs, in_ready_o, e);
            end
            if (q.size() == 0) in_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (obs !== 6'h00 || in_ready_o !== 1'b1) begin
            errors++; $display("FAIL hold_idle got out=%h rdy=%b exp out=00 rdy=1", obs, in_ready_o);
        end
    endtask

    task automatic test_abort_priority();
        exp_t e;
        use_b = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; abort = 1'b1; in_data = 8'hC3;
        #1;
        checks++;
        if (in_ready_o !== 1'b0) begin
            errors++; $display("FAIL prio_ready got %b exp 0", in_ready_o);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs !== 6'h00 || in_ready_o !== 1'b0) begin
                errors++; $display("FAIL prio_hold got out=%h rdy=%b exp out=00 rdy=0", obs, in_ready_o);
            end
        end
        abort = 1'b0;
        #1;
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++; $display("FAIL prio_release got %b exp 1", in_ready_o);
        end
        push_scan(8'hC3, 2);
        while (q.size() > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL prio_scan got %h exp %h", obs, e);
            end
        end
        @(negedge clk);
        checks++;
        if (obs !== 6'h00 || in_ready_o !== 1'b1) begin
            errors++; $display("FAIL prio_idle got out=%h rdy=%b exp out=00 rdy=1", obs, in_ready_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_dwell2();
        test_back_to_back();
        test_abort();
        test_reset_mid_scan();
        test_hold_word();
        test_abort_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
